// File: rtl/rll_key_load_ctrl_if.sv
// Bus bundle for the RLL32 key-load controller: control strobes, key stream and committed-key outputs.
// Both modports cover every signal; the controller takes the slave side.
//
// Stream handshake:
//  - A beat transfers on a rising clk edge where in_valid && in_ready are both high.
//  - in_ready depends only on controller state, never on in_valid.
//  - While in_valid is high, in_data is the beat on offer. The source may drop in_valid between beats.
//  - in_valid while in_ready is low transfers nothing and has no effect.
interface rll_key_load_ctrl_if #(
    parameter int KEY_BITS = 32,
    parameter int BEAT_W   = 8
);
    logic                start;
    logic                exp_par;
    logic                abort;
    logic                in_valid;
    logic [BEAT_W-1:0]   in_data;
    logic                in_ready;
    logic [KEY_BITS-1:0] key_out;
    logic                key_valid;
    logic                busy;
    logic                done;
    logic                err;
    logic                lockout;
    logic [1:0]          state_dbg;

    modport master (
        output start, exp_par, abort, in_valid, in_data,
        input  in_ready, key_out, key_valid, busy, done, err, lockout, state_dbg
    );

    modport slave (
        input  start, exp_par, abort, in_valid, in_data,
        output in_ready, key_out, key_valid, busy, done, err, lockout, state_dbg
    );
endinterface

// File: rtl/rll_key_load_ctrl.sv
// Key-load sequencer for an RLL32 locked netlist: assembles key beats, checks parity, commits atomically.
// Optional consecutive-failure lockout is enabled with `define KEY_FAIL_LOCKOUT_EN.
module rll_key_load_ctrl #(
    parameter int KEY_BITS = 32,
    parameter int BEAT_W   = 8,
    parameter int MAX_FAIL = 3
) (
    input logic              clk,
    input logic              rst,
    rll_key_load_ctrl_if.slave bus
);
    localparam int BEATS = KEY_BITS / BEAT_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    if ((KEY_BITS % BEAT_W) != 0 || BEATS < 2 || MAX_FAIL < 1) begin : g_cfg_check
        $error("rll_key_load_ctrl: unsupported KEY_BITS/BEAT_W/MAX_FAIL combination");
    end

`ifdef KEY_FAIL_LOCKOUT_EN
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_CHECK   = 2'd2,
        S_LOCKOUT = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_CHECK   = 2'd2
    } state_t;
`endif

    state_t              state, state_next;
    logic [KEY_BITS-1:0] shadow, shadow_next;
    logic [CNT_W-1:0]    beat_cnt, beat_cnt_next;
    logic                par_q, par_next;
    logic [KEY_BITS-1:0] key_out_q, key_out_next;
    logic                key_valid_q, key_valid_next;
    logic                busy_q, busy_next;
    logic                done_q, done_next;
    logic                err_q, err_next;
    logic                par_ok;

`ifdef KEY_FAIL_LOCKOUT_EN
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);
    localparam logic [FAIL_W-1:0] FAIL_LIMIT = FAIL_W'(MAX_FAIL);

    logic [FAIL_W-1:0] fail_cnt, fail_cnt_next, fail_cnt_inc;
    logic              lockout_q, lockout_next;

    // Saturating increment; the limit is reached at most once before the FSM parks in LOCKOUT.
    assign fail_cnt_inc = (fail_cnt == FAIL_LIMIT) ? fail_cnt : fail_cnt + FAIL_W'(1);
`endif

    assign par_ok = ((^shadow) == par_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        shadow_next    = shadow;
        beat_cnt_next  = beat_cnt;
        par_next       = par_q;
        key_out_next   = key_out_q;
        key_valid_next = key_valid_q;
        done_next      = 1'b0;
        err_next       = 1'b0;
`ifdef KEY_FAIL_LOCKOUT_EN
        fail_cnt_next  = fail_cnt;
        lockout_next   = lockout_q;
`endif

        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_next    = S_LOAD;
                    par_next      = bus.exp_par;
                    beat_cnt_next = '0;
                end
            end

            S_LOAD: begin
                // Abort takes priority: a beat offered in the same cycle is dropped.
                if (bus.abort) begin
                    state_next = S_IDLE;
                end else if (bus.in_valid) begin
                    shadow_next   = (shadow << BEAT_W) | KEY_BITS'(bus.in_data);
                    beat_cnt_next = beat_cnt + CNT_W'(1);
                    if (beat_cnt == LAST_BEAT) begin
                        state_next = S_CHECK;
                    end
                end
            end

            S_CHECK: begin
                state_next = S_IDLE;
                if (par_ok) begin
                    key_out_next   = shadow;
                    key_valid_next = 1'b1;
                    done_next      = 1'b1;
`ifdef KEY_FAIL_LOCKOUT_EN
                    fail_cnt_next  = '0;
`endif
                end else begin
                    // A failed reload also discards the previously committed key.
                    key_out_next   = '0;
                    key_valid_next = 1'b0;
                    err_next       = 1'b1;
`ifdef KEY_FAIL_LOCKOUT_EN
                    fail_cnt_next  = fail_cnt_inc;
                    if (fail_cnt_inc == FAIL_LIMIT) begin
                        state_next   = S_LOCKOUT;
                        lockout_next = 1'b1;
                    end
`endif
                end
            end

`ifdef KEY_FAIL_LOCKOUT_EN
            S_LOCKOUT: begin
                key_out_next   = '0;
                key_valid_next = 1'b0;
            end
`endif

            default: begin
                state_next = S_IDLE;
            end
        endcase

        busy_next = (state_next != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow      <= '0;
            beat_cnt    <= '0;
            par_q       <= 1'b0;
            key_out_q   <= '0;
            key_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            shadow      <= shadow_next;
            beat_cnt    <= beat_cnt_next;
            par_q       <= par_next;
            key_out_q   <= key_out_next;
            key_valid_q <= key_valid_next;
            busy_q      <= busy_next;
            done_q      <= done_next;
            err_q       <= err_next;
        end
    end

`ifdef KEY_FAIL_LOCKOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_cnt  <= '0;
            lockout_q <= 1'b0;
        end else begin
            fail_cnt  <= fail_cnt_next;
            lockout_q <= lockout_next;
        end
    end

    assign bus.lockout = lockout_q;
`else
    assign bus.lockout = 1'b0;
`endif

    assign bus.in_ready  = (state == S_LOAD);
    assign bus.key_out   = key_out_q;
    assign bus.key_valid = key_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_rll_key_load_ctrl.sv
// Randomized scoreboard bench for rll_key_load_ctrl; lockout scenarios follow `define KEY_FAIL_LOCKOUT_EN.
`timescale 1ns/1ps
module tb_rll_key_load_ctrl;
  localparam int KEY_BITS = 32;
  localparam int BEAT_W   = 8;
  localparam int MAX_FAIL = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  // Reference state: committed key as the spec's rules say it should be.
  logic [31:0] ref_key = '0;
  logic        ref_valid = 1'b0;
  int          ref_fail = 0;
  logic        ref_locked = 1'b0;

  // Expected completion events: {lockout, pass, assembled_key}
  logic [33:0] exp_q[$];

  rll_key_load_ctrl_if #(.KEY_BITS(KEY_BITS), .BEAT_W(BEAT_W)) bus ();

  rll_key_load_ctrl #(
    .KEY_BITS(KEY_BITS),
    .BEAT_W  (BEAT_W),
    .MAX_FAIL(MAX_FAIL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_key_out"},   bus.key_out,   0);
    check({tag, "_key_valid"}, bus.key_valid, 0);
    check({tag, "_in_ready"},  bus.in_ready,  0);
    check({tag, "_busy"},      bus.busy,      0);
    check({tag, "_done"},      bus.done,      0);
    check({tag, "_err"},       bus.err,       0);
    check({tag, "_lockout"},   bus.lockout,   0);
  endtask

  task automatic apply_reset();
    bus.start = 1'b0; bus.exp_par = 1'b0; bus.abort = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    ref_key = '0; ref_valid = 1'b0; ref_fail = 0; ref_locked = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- driver ----------------
  // gap: 0 = beat every cycle, 1 = in_valid 0/1 alternating starting low, 2 = random gaps.
  // abort_at: number of accepted beats after which abort is raised (-1 = never).
  task automatic do_load(input logic [31:0] kv, input logic ep, input int gap, input int abort_at);
    int   acc;
    int   s_cyc;
    int   n;
    logic v;
    logic pass;

    if (ref_locked) begin
      bus.start = 1'b1; bus.exp_par = ep; bus.in_valid = 1'b1; bus.in_data = kv[31:24];
      tick();
      bus.start = 1'b0; bus.in_valid = 1'b0;
      check("lock_busy",      bus.busy,      1);
      check("lock_in_ready",  bus.in_ready,  0);
      check("lock_key_valid", bus.key_valid, 0);
      check("lock_key_out",   bus.key_out,   0);
      tick();
      check("lock_stays",     bus.lockout,   1);
      return;
    end

    // A beat offered in IDLE must not be taken.
    bus.in_valid = 1'b1; bus.in_data = 8'($urandom);
    check("idle_in_ready", bus.in_ready, 0);
    bus.start = 1'b1; bus.exp_par = ep;
    tick();
    s_cyc = cyc;
    bus.start = 1'b0;

    acc = 0;
    while (acc < 4) begin
      if (acc == abort_at) begin
        bus.abort = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'($urandom); bus.start = 1'b0;
        tick();
        bus.abort = 1'b0; bus.in_valid = 1'b0;
        check("abort_busy",      bus.busy,      0);
        check("abort_in_ready",  bus.in_ready,  0);
        check("abort_key_out",   bus.key_out,   ref_key);
        check("abort_key_valid", bus.key_valid, ref_valid);
        return;
      end
      case (gap)
        0:       v = 1'b1;
        1:       v = ((cyc - s_cyc) % 2) == 1;
        default: v = 1'($urandom_range(0, 1));
      endcase
      bus.in_valid = v;
      bus.in_data  = kv[31-8*acc -: 8];
      // start and exp_par are noise while loading.
      bus.start    = ($urandom_range(0, 3) == 0);
      bus.exp_par  = ~ep;
      tick();
      if (v) acc++;
    end

    // Now in CHECK: old key still held, stream and abort must be ignored.
    bus.start = 1'b0;
    bus.in_valid = 1'($urandom_range(0, 1));
    bus.abort = 1'($urandom_range(0, 1));
    check("check_in_ready",  bus.in_ready,  0);
    check("check_busy",      bus.busy,      1);
    check("hold_key_out",    bus.key_out,   ref_key);
    check("hold_key_valid",  bus.key_valid, ref_valid);

    pass = ((^kv) == ep);
    if (pass) begin
      ref_key = kv; ref_valid = 1'b1; ref_fail = 0;
    end else begin
      ref_key = '0; ref_valid = 1'b0;
`ifdef KEY_FAIL_LOCKOUT_EN
      if (ref_fail < MAX_FAIL) ref_fail++;
      if (ref_fail == MAX_FAIL) ref_locked = 1'b1;
`endif
    end
    exp_q.push_back({ref_locked, pass, kv});

    n = 0;
    do begin
      tick();
      n++;
    end while (!(bus.done || bus.err) && n < 40);
    bus.abort = 1'b0; bus.in_valid = 1'b0;

    if (!(bus.done || bus.err)) begin
      tests++; fails++;
      $display("FAIL completion_timeout: no done/err within %0d cycles", n);
    end else if (gap < 2) begin
      check("latency", cyc - s_cyc, (gap == 0) ? 5 : 9);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [33:0] e;
    if (!rst && (bus.done || bus.err)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {bus.done, bus.err}, 0);
      end else begin
        e = exp_q.pop_front();
        check("ev_done",      bus.done,      e[32]);
        check("ev_err",       bus.err,       !e[32]);
        check("ev_key_out",   bus.key_out,   e[32] ? {32'h0, e[31:0]} : 64'h0);
        check("ev_key_valid", bus.key_valid, e[32]);
        check("ev_lockout",   bus.lockout,   e[33]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] kv;
    logic        ep;
    int          ab;

    apply_reset();
    tick();
    check_all_zero("post_reset");

    // Basic good key, then same beats with bad parity.
    do_load(32'hA53C0FF0, 1'b0, 0, -1);
    do_load(32'hA53C0FF0, 1'b1, 0, -1);
    check("bad_par_lockout", bus.lockout, 0);

    // Good key, then an aborted reload keeps it.
    do_load(32'hA53C0FF0, 1'b0, 0, -1);
    do_load(32'hCAFEBABE, 1'b0, 0, 2);

    // Alternating in_valid stretches the load by four cycles.
    do_load(32'hA53C0FF0, 1'b0, 1, -1);

    // Three consecutive bad loads, then a fourth attempt.
    for (int i = 0; i < 3; i++) do_load(32'h12345678, 1'b0, 0, -1);
    do_load(32'hA53C0FF0, 1'b0, 0, -1);
    check("after_three_fails_lockout", bus.lockout, ref_locked);

    // Reset mid-load, then a fresh load.
    bus.start = 1'b1; bus.exp_par = 1'b0;
    tick();
    bus.start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'h12; tick();
    bus.in_data = 8'h34; tick();
    apply_reset();
    do_load(32'h12345678, 1'b1, 0, -1);

    // Randomized loads: mixed parity, gaps, aborts.
    for (int i = 0; i < 40; i++) begin
      kv = $urandom;
      ep = (^kv) ^ ($urandom_range(0, 3) == 0);
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
      do_load(kv, ep, int'($urandom_range(0, 2)), ab);
      if (ref_locked && $urandom_range(0, 1) == 1) begin
        do_load(kv, ep, 0, -1);
        apply_reset();
      end
    end

    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
